// File: rtl/sixteen_bit_adder_pkg.sv
// Shared types and widths for the registered 16-bit adder.
// Exports ADD_W, ADD_MSB and the word_t operand/result type.
package adder_pkg;

    localparam int ADD_W   = 16;
    localparam int ADD_MSB = ADD_W - 1;

    typedef logic [ADD_W-1:0] word_t;

endpackage

// File: rtl/sixteen_bit_adder_if.sv
// Operand/result bundle for the adder stage.
// master: drives in_valid/a/b/cin; slave: drives out_valid/z/cout/ovf.
interface sixteen_bit_adder_if;
    import adder_pkg::*;

    logic  in_valid;
    word_t a;
    word_t b;
    logic  cin;
    logic  out_valid;
    word_t z;
    logic  cout;
    logic  ovf;

    modport master (
        output in_valid, a, b, cin,
        input  out_valid, z, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, z, cout, ovf
    );

endinterface

// File: rtl/sixteen_bit_adder_full_adder.sv
// One-bit combinational full adder cell of the ripple chain.
// Ports: a, b, ci in; s (sum), co (carry) out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sixteen_bit_adder.sv
// Registered ripple-carry adder: {cout,z} = a + b + cin, one cycle.
// Ports: clk, rst (async, active-high), bus (slave side of the bundle).
module sixteen_bit_adder #(
    parameter int WIDTH = adder_pkg::ADD_W
) (
    input  logic                clk,
    input  logic                rst,
    sixteen_bit_adder_if.slave  bus
);
    import adder_pkg::*;

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] z_d, z_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;

    assign carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Data holds when idle so stale/X operands never reach the outputs.
    always_comb begin
        valid_d = bus.in_valid;
        z_d     = z_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (bus.in_valid) begin
            z_d    = sum;
            cout_d = carry[WIDTH];
            ovf_d  = (bus.a[MSB] == bus.b[MSB])
                  && (sum[MSB] != bus.a[MSB]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            z_q     <= z_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.z         = z_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sixteen_bit_adder.sv
// Self-checking bench for sixteen_bit_adder: directed cases, streaming,
// hold, reset scenarios and a randomized run against a reference model.
module tb_sixteen_bit_adder;
    import adder_pkg::*;

    typedef struct packed {
        word_t z;
        logic  cout;
        logic  ovf;
    } exp_t;

    logic clk;
    logic rst;
    logic run;

    int checks   = 0;
    int failures = 0;

    exp_t  sb[$];
    word_t hz;
    logic  hcout;
    logic  hovf;

    sixteen_bit_adder_if bus ();

    sixteen_bit_adder #(.WIDTH(ADD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always begin
        #5;
        if (run) clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input word_t ia, input word_t ib,
                                   input logic ic);
        logic [ADD_W:0] full;
        exp_t e;
        full   = {1'b0, ia} + {1'b0, ib} + {{ADD_W{1'b0}}, ic};
        e.z    = full[ADD_W-1:0];
        e.cout = full[ADD_W];
        e.ovf  = (ia[ADD_MSB] == ib[ADD_MSB])
              && (full[ADD_MSB] != ia[ADD_MSB]);
        return e;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, ".z"},         {16'b0, bus.z},         32'd0);
        chk({tag, ".cout"},      {31'b0, bus.cout},      32'd0);
        chk({tag, ".ovf"},       {31'b0, bus.ovf},       32'd0);
    endtask

    task automatic chk_out(input string tag, input logic v);
        exp_t e;
        chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, v});
        if (v) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL %s.scoreboard observed=empty expected=entry",
                       tag);
            end else begin
                e     = sb.pop_front();
                hz    = e.z;
                hcout = e.cout;
                hovf  = e.ovf;
            end
        end
        chk({tag, ".z"},    {16'b0, bus.z},    {16'b0, hz});
        chk({tag, ".cout"}, {31'b0, bus.cout}, {31'b0, hcout});
        chk({tag, ".ovf"},  {31'b0, bus.ovf},  {31'b0, hovf});
    endtask

    task automatic step(input string tag, input logic v,
                        input word_t ia, input word_t ib, input logic ic);
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = ia;
        bus.b        = ib;
        bus.cin      = ic;
        if (v) sb.push_back(model(ia, ib, ic));
        @(posedge clk);
        #1;
        chk_out(tag, v);
    endtask

    // Accept an operand, then reset before the result edge.
    task automatic rst_mid(input string tag, input word_t ia,
                           input word_t ib, input logic ic);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = ia;
        bus.b        = ib;
        bus.cin      = ic;
        #2;
        rst = 1'b1;
        #1;
        chk_zero({tag, ".async"});
        @(posedge clk);
        #1;
        chk_zero({tag, ".edge"});
        sb.delete();
        hz    = '0;
        hcout = 1'b0;
        hovf  = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        clk          = 1'b0;
        run          = 1'b0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        hz           = '0;
        hcout        = 1'b0;
        hovf         = 1'b0;

        #3;
        rst = 1'b1;
        #1;
        chk_zero("reset_noclk");

        run = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 16'h1234;
        bus.b        = 16'h1111;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_held");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;

        step("basic",    1'b1, 16'h0001, 16'h0000, 1'b0);
        step("wrap",     1'b1, 16'hFFFF, 16'h0001, 1'b0);
        step("ffff_cin", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        step("ovf_pos",  1'b1, 16'h7FFF, 16'h0001, 1'b0);
        step("ovf_neg",  1'b1, 16'h8000, 16'h8000, 1'b0);
        step("cin_only", 1'b1, 16'h0000, 16'h0000, 1'b1);

        step("stream1", 1'b1, 16'd1, 16'd1, 1'b0);
        step("stream2", 1'b1, 16'd2, 16'd2, 1'b0);
        step("stream3", 1'b1, 16'd3, 16'd3, 1'b0);
        step("hold",    1'b0, 16'd9, 16'd9, 1'b0);
        chk("hold_z6", {16'b0, bus.z}, 32'd6);
        step("hold_x",  1'b0, 'x, 'x, 1'bx);
        chk("hold_x_z6", {16'b0, bus.z}, 32'd6);

        rst_mid("rst_mid", 16'h0102, 16'h0304, 1'b0);
        step("after_rst_idle", 1'b0, 16'h0, 16'h0, 1'b0);
        step("after_rst",      1'b1, 16'h00F0, 16'h000F, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(199) == 0) begin
                rst_mid("rand_rst", word_t'($urandom),
                        word_t'($urandom), 1'($urandom));
            end else begin
                step("rand", 1'($urandom_range(3) != 0),
                     word_t'($urandom), word_t'($urandom),
                     1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
